tick_mode_register: RTL and testbench



---
 rtl/tick_mode_register_if.sv | 26 ++
 rtl/tick_mode_register.sv | 120 ++++++++++++
 tb/tb_tick_mode_register.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_mode_register_if.sv
// Bus bundle for tick_mode_register: operation controls in, register state and pulses out.
// The master samples q/so/op_stb/changed and drives the controls; nothing here handshakes.
interface tick_mode_register_if #(
   parameter int DATAWIDTH = 8
);
   logic                 sclr;
   logic                 tg_tick;
   logic [2:0]           mode;
   logic [DATAWIDTH-1:0] d;
   logic [DATAWIDTH-1:0] mask;
   logic                 si;
   logic [DATAWIDTH-1:0] q;
   logic                 so;
   logic                 op_stb;
   logic                 changed;

   modport master (
      output sclr, tg_tick, mode, d, mask, si,
      input  q, so, op_stb, changed
   );

   modport slave (
      input  sclr, tg_tick, mode, d, mask, si,
      output q, so, op_stb, changed
   );
endinterface

// File: rtl/tick_mode_register.sv
// Multi-mode register applying one hold/load/toggle/set/clear/shift/rotate operation
// every PRESCALE tg_tick pulses; results, so, op_stb and changed appear one clk later.
module tick_mode_register #(
   parameter int                   DATAWIDTH   = 8,
   parameter int                   PRESCALE    = 1,
   parameter logic [DATAWIDTH-1:0] RESET_VALUE = {DATAWIDTH{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst,
   tick_mode_register_if.slave  bus
);

   typedef enum logic [2:0] {
      MODE_HOLD   = 3'b000,
      MODE_LOAD   = 3'b001,
      MODE_TOGGLE = 3'b010,
      MODE_SET    = 3'b011,
      MODE_CLEAR  = 3'b100,
      MODE_SHL    = 3'b101,
      MODE_SHR    = 3'b110,
      MODE_ROTL   = 3'b111
   } mode_e;

   localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

   logic [DATAWIDTH-1:0] q_q, q_d;
   logic [PW-1:0]        pre_q, pre_d;
   logic                 so_q, so_d;
   logic                 stb_q, stb_d;
   logic                 chg_q, chg_d;

   logic [DATAWIDTH-1:0] shl_v, shr_v, rotl_v, nq;
   logic                 nso;
   logic                 apply;
   mode_e                mode;

   assign mode  = mode_e'(bus.mode);
   assign apply = bus.tg_tick && (pre_q == PRE_LAST);

   // A 1-bit register has no interior bits: shifts just take si and rotate is a no-op.
   if (DATAWIDTH == 1) begin : g_w1
      assign shl_v  = bus.si;
      assign shr_v  = bus.si;
      assign rotl_v = q_q;
   end else begin : g_wn
      assign shl_v  = {q_q[DATAWIDTH-2:0], bus.si};
      assign shr_v  = {bus.si, q_q[DATAWIDTH-1:1]};
      assign rotl_v = {q_q[DATAWIDTH-2:0], q_q[DATAWIDTH-1]};
   end

   always_comb begin
      nq  = q_q;
      nso = so_q;
      case (mode)
         MODE_HOLD:   nq = q_q;
         MODE_LOAD:   nq = (q_q & ~bus.mask) | (bus.d & bus.mask);
         MODE_TOGGLE: nq = q_q ^ bus.mask;
         MODE_SET:    nq = q_q | bus.mask;
         MODE_CLEAR:  nq = q_q & ~bus.mask;
         MODE_SHL: begin
            nq  = shl_v;
            nso = q_q[DATAWIDTH-1];
         end
         MODE_SHR: begin
            nq  = shr_v;
            nso = q_q[0];
         end
         MODE_ROTL: begin
            nq  = rotl_v;
            nso = q_q[DATAWIDTH-1];
         end
         default: nq = q_q;
      endcase
   end

   // sclr outranks a coincident tick and discards any partial prescale count.
   always_comb begin
      q_d   = q_q;
      pre_d = pre_q;
      so_d  = so_q;
      stb_d = 1'b0;
      chg_d = 1'b0;
      if (bus.sclr) begin
         q_d   = RESET_VALUE;
         pre_d = '0;
         chg_d = (q_q != RESET_VALUE);
      end else if (apply) begin
         q_d   = nq;
         pre_d = '0;
         so_d  = nso;
         stb_d = 1'b1;
         chg_d = (nq != q_q);
      end else if (bus.tg_tick) begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q   <= RESET_VALUE;
         pre_q <= '0;
         so_q  <= 1'b0;
         stb_q <= 1'b0;
         chg_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         pre_q <= pre_d;
         so_q  <= so_d;
         stb_q <= stb_d;
         chg_q <= chg_d;
      end
   end

   assign bus.q       = q_q;
   assign bus.so      = so_q;
   assign bus.op_stb  = stb_q;
   assign bus.changed = chg_q;

endmodule

// File: tb/tb_tick_mode_register.sv
// Bench for tick_mode_register: three configurations driven in lockstep, checked against
// an arithmetic reference model plus directed scenarios with fixed expected values.
module tb_tick_mode_register;

   localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_TOG = 3'd2, M_SET = 3'd3;
   localparam logic [2:0] M_CLR  = 3'd4, M_SHL  = 3'd5, M_SHR = 3'd6, M_ROTL = 3'd7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tick_mode_register_if #(.DATAWIDTH(8)) if_a ();
   tick_mode_register_if #(.DATAWIDTH(8)) if_b ();
   tick_mode_register_if #(.DATAWIDTH(1)) if_c ();

   tick_mode_register #(.DATAWIDTH(8), .PRESCALE(3), .RESET_VALUE(8'hA5))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   tick_mode_register #(.DATAWIDTH(8), .PRESCALE(1), .RESET_VALUE(8'h00))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));
   tick_mode_register #(.DATAWIDTH(1), .PRESCALE(1), .RESET_VALUE(1'b0))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));

   int n_checks = 0;
   int n_fail   = 0;
   int a_stb_cnt = 0;
   int a_chg_cnt = 0;

   // Reference model state, one slot per DUT (a, b, c).
   int         p_w   [3] = '{8, 8, 1};
   int         p_pre [3] = '{3, 1, 1};
   logic [7:0] p_rv  [3] = '{8'hA5, 8'h00, 8'h00};
   logic [7:0] m_q   [3];
   logic       m_so  [3];
   int         m_cnt [3];
   logic       m_stb [3];
   logic       m_chg [3];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] get_q(input int k);
      case (k)
         0:       return if_a.q;
         1:       return if_b.q;
         default: return {7'b0, if_c.q};
      endcase
   endfunction

   function automatic logic [3:0] get_flags(input int k);
      case (k)
         0:       return {1'b0, if_a.so, if_a.op_stb, if_a.changed};
         1:       return {1'b0, if_b.so, if_b.op_stb, if_b.changed};
         default: return {1'b0, if_c.so, if_c.op_stb, if_c.changed};
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_q[k] = p_rv[k]; m_so[k] = 1'b0; m_cnt[k] = 0; m_stb[k] = 1'b0; m_chg[k] = 1'b0;
      end
   endtask

   // Operation result as plain arithmetic on a w-bit value.
   task automatic ref_op(input logic [7:0] q, input int w, input logic [2:0] m,
                         input logic [7:0] d, input logic [7:0] mask, input logic si,
                         output logic [7:0] nq, output logic so_upd, output logic so_v);
      logic [7:0] wm, dm, mm, msb;
      wm  = 8'hFF >> (8 - w);
      dm  = d & wm;
      mm  = mask & wm;
      msb = (q >> (w - 1)) & 8'h01;
      so_upd = 1'b0;
      so_v   = 1'b0;
      case (m)
         M_LOAD: nq = (q & ~mm) | (dm & mm);
         M_TOG:  nq = q ^ mm;
         M_SET:  nq = q | mm;
         M_CLR:  nq = q & ~mm;
         M_SHL:  begin nq = (q << 1) | {7'b0, si};       so_upd = 1'b1; so_v = msb[0]; end
         M_SHR:  begin nq = (q >> 1) | ({7'b0, si} << (w - 1)); so_upd = 1'b1; so_v = q[0]; end
         M_ROTL: begin nq = (q << 1) | msb;              so_upd = 1'b1; so_v = msb[0]; end
         default: nq = q;
      endcase
      nq = nq & wm;
   endtask

   task automatic model_step(input int k, input logic s, input logic t, input logic [2:0] m,
                             input logic [7:0] d, input logic [7:0] mask, input logic si);
      logic [7:0] nq;
      logic       su, sv;
      m_stb[k] = 1'b0;
      m_chg[k] = 1'b0;
      if (s) begin
         m_chg[k] = (m_q[k] != p_rv[k]);
         m_q[k]   = p_rv[k];
         m_cnt[k] = 0;
      end else if (t) begin
         m_cnt[k] = m_cnt[k] + 1;
         if (m_cnt[k] == p_pre[k]) begin
            m_cnt[k] = 0;
            ref_op(m_q[k], p_w[k], m, d, mask, si, nq, su, sv);
            m_stb[k] = 1'b1;
            m_chg[k] = (nq != m_q[k]);
            m_q[k]   = nq;
            if (su) m_so[k] = sv;
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] f;
      for (int k = 0; k < 3; k++) begin
         f = get_flags(k);
         check_eq($sformatf("model_q%0d", k),       {24'b0, get_q(k)}, {24'b0, m_q[k]});
         check_eq($sformatf("model_so%0d", k),      {31'b0, f[2]},     {31'b0, m_so[k]});
         check_eq($sformatf("model_op_stb%0d", k),  {31'b0, f[1]},     {31'b0, m_stb[k]});
         check_eq($sformatf("model_changed%0d", k), {31'b0, f[0]},     {31'b0, m_chg[k]});
      end
   endtask

   task automatic drive(input logic s, input logic t, input logic [2:0] m,
                        input logic [7:0] d, input logic [7:0] mask, input logic si);
      if_a.sclr = s; if_a.tg_tick = t; if_a.mode = m; if_a.d = d;    if_a.mask = mask;    if_a.si = si;
      if_b.sclr = s; if_b.tg_tick = t; if_b.mode = m; if_b.d = d;    if_b.mask = mask;    if_b.si = si;
      if_c.sclr = s; if_c.tg_tick = t; if_c.mode = m; if_c.d = d[0]; if_c.mask = mask[0]; if_c.si = si;
   endtask

   // One clock: drive, let the edge happen, advance the model, compare everything.
   task automatic step(input logic s, input logic t, input logic [2:0] m,
                       input logic [7:0] d, input logic [7:0] mask, input logic si);
      drive(s, t, m, d, mask, si);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) model_step(k, s, t, m, d, mask, si);
      if (if_a.op_stb)  a_stb_cnt++;
      if (if_a.changed) a_chg_cnt++;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, M_HOLD, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic mid_clock_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("rst_async_q_a",  {24'b0, if_a.q}, 32'hA5);
      check_eq("rst_async_so_a", {31'b0, if_a.so}, 32'h0);
      check_eq("rst_async_stb_a", {31'b0, if_a.op_stb}, 32'h0);
      check_eq("rst_async_chg_a", {31'b0, if_a.changed}, 32'h0);
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      drive(1'b0, 1'b0, M_HOLD, 8'h00, 8'h00, 1'b0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;
      idle(2);

      // Disturb state, then reset mid-clock and confirm it holds without ticks.
      step(1'b0, 1'b1, M_TOG, 8'h00, 8'hFF, 1'b1);
      step(1'b0, 1'b1, M_SHL, 8'h00, 8'h00, 1'b1);
      mid_clock_reset();
      idle(3);
      check_eq("rst_hold_q_a", {24'b0, if_a.q}, 32'hA5);

      // Toggle with prescale 3 on dut_a, starting from q=00.
      step(1'b1, 1'b0, M_HOLD, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, M_LOAD, 8'h00, 8'hFF, 1'b0);
      check_eq("pre_load_q_a", {24'b0, if_a.q}, 32'h00);
      a_stb_cnt = 0;
      a_chg_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b1, M_TOG, 8'h00, 8'h0F, 1'b0);
         if (i == 3) check_eq("tog_tick3_q_a", {24'b0, if_a.q}, 32'h0F);
         if (i == 6) check_eq("tog_tick6_q_a", {24'b0, if_a.q}, 32'h00);
         idle(1);
      end
      check_eq("tog_op_stb_count", a_stb_cnt, 2);
      check_eq("tog_changed_count", a_chg_cnt, 2);

      // Masked ops and shifts on dut_b (prescale 1).
      step(1'b1, 1'b0, M_HOLD, 8'h00, 8'h00, 1'b0);
      step(1'b0, 1'b1, M_LOAD, 8'hFF, 8'h3C, 1'b0);
      check_eq("load_q_b", {24'b0, if_b.q}, 32'h3C);
      step(1'b0, 1'b1, M_SET, 8'h00, 8'h81, 1'b0);
      check_eq("set_q_b", {24'b0, if_b.q}, 32'hBD);
      step(1'b0, 1'b1, M_CLR, 8'h00, 8'h0C, 1'b0);
      check_eq("clear_q_b", {24'b0, if_b.q}, 32'hB1);
      step(1'b0, 1'b1, M_HOLD, 8'hFF, 8'hFF, 1'b1);
      check_eq("hold_q_b", {24'b0, if_b.q}, 32'hB1);
      check_eq("hold_stb_b", {31'b0, if_b.op_stb}, 32'h1);
      check_eq("hold_chg_b", {31'b0, if_b.changed}, 32'h0);
      step(1'b0, 1'b1, M_LOAD, 8'h80, 8'hFF, 1'b0);
      step(1'b0, 1'b1, M_SHL, 8'h00, 8'h00, 1'b1);
      check_eq("shl_q_b", {24'b0, if_b.q}, 32'h01);
      check_eq("shl_so_b", {31'b0, if_b.so}, 32'h1);
      step(1'b0, 1'b1, M_SHR, 8'h00, 8'h00, 1'b0);
      check_eq("shr_q_b", {24'b0, if_b.q}, 32'h00);
      check_eq("shr_so_b", {31'b0, if_b.so}, 32'h1);
      step(1'b0, 1'b1, M_LOAD, 8'h81, 8'hFF, 1'b0);
      step(1'b0, 1'b1, M_ROTL, 8'h00, 8'h00, 1'b0);
      check_eq("rotl_q_b", {24'b0, if_b.q}, 32'h03);
      check_eq("rotl_so_b", {31'b0, if_b.so}, 32'h1);

      // sclr coincident with a tick on dut_a restarts the prescale count.
      step(1'b1, 1'b0, M_HOLD, 8'h00, 8'h00, 1'b0);
      step(1'b0, 1'b1, M_TOG, 8'h00, 8'hFF, 1'b0);
      step(1'b0, 1'b1, M_TOG, 8'h00, 8'hFF, 1'b0);
      step(1'b1, 1'b1, M_TOG, 8'h00, 8'hFF, 1'b0);
      check_eq("sclr_tick_q_a", {24'b0, if_a.q}, 32'hA5);
      check_eq("sclr_tick_stb_a", {31'b0, if_a.op_stb}, 32'h0);
      step(1'b0, 1'b1, M_TOG, 8'h00, 8'hFF, 1'b0);
      check_eq("after_sclr_t1_stb_a", {31'b0, if_a.op_stb}, 32'h0);
      step(1'b0, 1'b1, M_TOG, 8'h00, 8'hFF, 1'b0);
      check_eq("after_sclr_t2_stb_a", {31'b0, if_a.op_stb}, 32'h0);
      step(1'b0, 1'b1, M_TOG, 8'h00, 8'hFF, 1'b0);
      check_eq("after_sclr_t3_stb_a", {31'b0, if_a.op_stb}, 32'h1);
      check_eq("after_sclr_t3_q_a", {24'b0, if_a.q}, 32'h5A);

      // Width-1 register on dut_c.
      step(1'b1, 1'b0, M_HOLD, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, M_TOG, 8'h00, 8'h01, 1'b0);
         check_eq("w1_tog_q", {31'b0, if_c.q}, (i % 2 == 0) ? 32'h1 : 32'h0);
         check_eq("w1_tog_chg", {31'b0, if_c.changed}, 32'h1);
         idle(3);
      end
      step(1'b0, 1'b1, M_SHL, 8'h00, 8'h00, 1'b1);
      check_eq("w1_shl_q", {31'b0, if_c.q}, 32'h1);
      check_eq("w1_shl_so", {31'b0, if_c.so}, 32'h0);

      // Randomized traffic, including level-high ticks and a mid-run reset.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) mid_clock_reset();
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
              3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
